mac_arbiter: RTL and testbench

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_arbiter_if.sv | 34 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/mac_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mac_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the MAC arbiter slice.
// Holds the FSM state encoding, operand/result widths, default job
// parameters and the two-way round-robin pick helper.
package mac_pkg;

  localparam int OPD_W       = 4;   // operand width
  localparam int RES_W       = 12;  // accumulated result width
  localparam int CNT_W       = 5;   // pair counter width (counts up to 16)
  localparam int WAIT_W      = 8;   // WAIT-state cycle counter width
  localparam int N_PAIRS_DEF = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // One-hot pick between two requesters; on a tie the one not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mac_arbiter_if.sv
// mac_arbiter_if -- bundles the requester handshakes, the response bus and
// the external MAC datapath control of the arbiter.
//   slave  : arbiter side (drives gnt*, opd_ready*, rsp_*, mac_go/en/a/b)
//   master : environment side (drives req*, opd_valid*, a*/b*, mac_out/done)
interface mac_arbiter_if;
  import mac_pkg::*;

  logic             req0, req1;
  logic             gnt0, gnt1;
  logic             opd_valid0, opd_valid1;
  logic [OPD_W-1:0] a0, b0, a1, b1;
  logic             opd_ready0, opd_ready1;
  logic             rsp_valid0, rsp_valid1;
  logic [RES_W-1:0] rsp_data;
  logic             rsp_err;
  logic             mac_go;
  logic             mac_en;
  logic [OPD_W-1:0] mac_a, mac_b;
  logic [RES_W-1:0] mac_out;
  logic             mac_done;

  modport slave (
    input  req0, req1, opd_valid0, opd_valid1, a0, b0, a1, b1, mac_out, mac_done,
    output gnt0, gnt1, opd_ready0, opd_ready1, rsp_valid0, rsp_valid1,
           rsp_data, rsp_err, mac_go, mac_en, mac_a, mac_b
  );

  modport master (
    output req0, req1, opd_valid0, opd_valid1, a0, b0, a1, b1, mac_out, mac_done,
    input  gnt0, gnt1, opd_ready0, opd_ready1, rsp_valid0, rsp_valid1,
           rsp_data, rsp_err, mac_go, mac_en, mac_a, mac_b
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin grant with a last-served pointer.
//   clk, rst : clock, async active-high reset (pointer resets to 1 so
//              requester 0 wins the first tie)
//   req      : request vector {req1, req0}
//   upd      : strobe recording that upd_id has just been served
//   upd_id   : index of the served requester
//   gnt      : combinational one-hot (or zero) grant
module rr_arb2
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);

  logic last_r;

  // Grant selection from current requests and pointer.
  always_comb begin
    gnt = rr_pick(req, last_r);
  end

  // Last-served pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (upd) begin
      last_r <= upd_id;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter -- shares one external MAC datapath between two requesters.
// A job is: grant, clear accumulator (mac_go), stream N_PAIRS operand
// pairs (mac_en per accepted pair), wait for mac_done or TIMEOUT, then
// pulse the owner's rsp_valid with rsp_data/rsp_err.
//   clk, rst : clock, async active-high reset (abandons any job silently)
//   bus      : mac_arbiter_if.slave (requests, operands, responses, MAC control)
module mac_arbiter
  import mac_pkg::*;
#(
  parameter int N_PAIRS = N_PAIRS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
)
(
  input  logic          clk,
  input  logic          rst,
  mac_arbiter_if.slave  bus
);

  state_e           state_r, state_s;
  logic [1:0]       arb_gnt_s;
  logic             gnt0_r, gnt1_r;
  logic             mac_go_r;
  logic             opd_ready0_r, opd_ready1_r;
  logic             rsp_valid0_r, rsp_valid1_r;
  logic [RES_W-1:0] rsp_data_r;
  logic             rsp_err_r;
  logic [CNT_W-1:0] pair_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic             accept_s;
  logic             last_pair_s;
  logic             done_hit_s;
  logic             timeout_hit_s;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1, bus.req0}),
    .upd    (state_r == ST_RESP),
    .upd_id (gnt1_r),
    .gnt    (arb_gnt_s)
  );

  // opd_ready is only ever high for the owner in STREAM, so this is the accept.
  assign accept_s    = (bus.opd_valid0 & opd_ready0_r) | (bus.opd_valid1 & opd_ready1_r);
  assign last_pair_s = accept_s & (pair_cnt_r == CNT_W'(N_PAIRS - 1));

  // Next-state decode and WAIT exit cause.
  always_comb begin
    state_s       = state_r;
    done_hit_s    = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_STREAM;
      end
      ST_STREAM: begin
        // a stalled owner may sit here forever; no timeout applies
        if (last_pair_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_WAIT: begin
        // mac_done wins even on the final allowed cycle
        if (bus.mac_done) begin
          done_hit_s = 1'b1;
          state_s    = ST_RESP;
        end else if (wait_cnt_r == WAIT_W'(TIMEOUT - 1)) begin
          timeout_hit_s = 1'b1;
          state_s       = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant register: latched on entry to START, held until return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
    end else if (state_s == ST_START) begin
      gnt0_r <= arb_gnt_s[0];
      gnt1_r <= arb_gnt_s[1];
    end else if (state_s == ST_IDLE) begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
    end else begin
      gnt0_r <= gnt0_r;
      gnt1_r <= gnt1_r;
    end
  end

  // Control strobes registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_go_r     <= 1'b0;
      opd_ready0_r <= 1'b0;
      opd_ready1_r <= 1'b0;
      rsp_valid0_r <= 1'b0;
      rsp_valid1_r <= 1'b0;
    end else begin
      mac_go_r     <= (state_s == ST_START);
      opd_ready0_r <= (state_s == ST_STREAM) & gnt0_r;
      opd_ready1_r <= (state_s == ST_STREAM) & gnt1_r;
      rsp_valid0_r <= (state_s == ST_RESP) & gnt0_r;
      rsp_valid1_r <= (state_s == ST_RESP) & gnt1_r;
    end
  end

  // Response capture; value persists until the next job completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_r <= {RES_W{1'b0}};
      rsp_err_r  <= 1'b0;
    end else if (done_hit_s) begin
      rsp_data_r <= bus.mac_out;
      rsp_err_r  <= 1'b0;
    end else if (timeout_hit_s) begin
      rsp_data_r <= {RES_W{1'b0}};
      rsp_err_r  <= 1'b1;
    end else begin
      rsp_data_r <= rsp_data_r;
      rsp_err_r  <= rsp_err_r;
    end
  end

  // Pair counter (cleared in START) and WAIT cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt_r <= {CNT_W{1'b0}};
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      if (state_r == ST_START) begin
        pair_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        pair_cnt_r <= pair_cnt_r + CNT_W'(1);
      end else begin
        pair_cnt_r <= pair_cnt_r;
      end
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
    end
  end

  assign bus.gnt0       = gnt0_r;
  assign bus.gnt1       = gnt1_r;
  assign bus.mac_go     = mac_go_r;
  assign bus.opd_ready0 = opd_ready0_r;
  assign bus.opd_ready1 = opd_ready1_r;
  assign bus.rsp_valid0 = rsp_valid0_r;
  assign bus.rsp_valid1 = rsp_valid1_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_err    = rsp_err_r;
  // mac_en must follow the handshake in the same cycle, hence combinational.
  assign bus.mac_en     = accept_s;
  assign bus.mac_a      = gnt0_r ? bus.a0 : (gnt1_r ? bus.a1 : {OPD_W{1'b0}});
  assign bus.mac_b      = gnt0_r ? bus.b0 : (gnt1_r ? bus.b1 : {OPD_W{1'b0}});

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter -- directed bench for mac_arbiter with a small external
// MAC model (clear on mac_go, accumulate on mac_en, done 2 cycles after the
// 16th mac_en unless disabled).
module tb_mac_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mac_arbiter_if bus ();

  mac_arbiter #(.N_PAIRS(16), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external MAC model ----------------
  logic [11:0] acc;
  int          en_cnt;
  logic [1:0]  dpipe;
  logic        done_en;
  logic        spur_done;
  int          v0cnt, v1cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= 12'd0;
      en_cnt <= 0;
      dpipe  <= 2'b00;
    end else begin
      if (bus.mac_go) begin
        acc    <= 12'd0;
        en_cnt <= 0;
      end else if (bus.mac_en) begin
        acc    <= acc + 12'(bus.mac_a) * 12'(bus.mac_b);
        en_cnt <= en_cnt + 1;
      end
      dpipe <= {dpipe[0], bus.mac_en && (en_cnt == 15)};
    end
  end

  assign bus.mac_out  = acc;
  assign bus.mac_done = (dpipe[1] & done_en) | spur_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v0cnt <= v0cnt;
      v1cnt <= v1cnt;
    end else begin
      if (bus.rsp_valid0) v0cnt <= v0cnt + 1;
      if (bus.rsp_valid1) v1cnt <= v1cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ab(input int who, input logic [3:0] av, input logic [3:0] bv);
    if (who == 0) begin bus.a0 = av; bus.b0 = bv; end
    else begin bus.a1 = av; bus.b1 = bv; end
  endtask

  task automatic set_valid(input int who, input logic v);
    if (who == 0) bus.opd_valid0 = v;
    else bus.opd_valid1 = v;
  endtask

  // Streams npairs pairs from the first STREAM cycle; optional valid gap
  // (with request drop) and one spurious mac_done pulse.
  task automatic stream(input int who, input logic [3:0] av, input logic [3:0] bv,
                        input int npairs, input int gap_at, input int gap_len,
                        input int spur_at, input bit drop);
    int sent = 0; int gap = 0; int budget = 0;
    bit v; bit rdy; bit first = 1'b1; bit spurred = 1'b0;
    set_ab(who, av, bv);
    while (sent < npairs && budget < 100) begin
      v = !(sent == gap_at && gap < gap_len);
      spur_done = (sent == spur_at) && !spurred;
      if (spur_done) spurred = 1'b1;
      set_valid(who, v);
      if (!v && drop) begin
        if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
      @(negedge clk);
      rdy = (who == 0) ? bus.opd_ready0 : bus.opd_ready1;
      if (!v) begin
        chk("gap_mac_en", bus.mac_en, 0);
        chk("gap_ready", rdy, 1);
        gap++;
      end else if (rdy) begin
        if (first) begin
          chk("mac_a", bus.mac_a, av);
          chk("mac_b", bus.mac_b, bv);
          chk("mac_en", bus.mac_en, 1);
          chk("other_ready", (who == 0) ? bus.opd_ready1 : bus.opd_ready0, 0);
          first = 1'b0;
        end
        sent++;
      end
      @(posedge clk); #1;
      budget++;
    end
    set_valid(who, 1'b0);
    spur_done = 1'b0;
    chk("stream_pairs", sent, npairs);
  endtask

  // Full job starting in an IDLE cycle (requests already set), ending in
  // the IDLE cycle after RESP.
  task automatic job(input int who, input logic [3:0] av, input logic [3:0] bv,
                     input int gap_at, input int gap_len, input int spur_at, input bit drop,
                     input logic [11:0] exp_data, input logic exp_err, input int exp_wait);
    int n = 0; bit hit = 1'b0;
    @(negedge clk);
    chk("idle_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("idle_mac_go", bus.mac_go, 0);
    chk("idle_rsp_valid", {bus.rsp_valid1, bus.rsp_valid0}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_gnt", {bus.gnt1, bus.gnt0}, (who == 0) ? 1 : 2);
    chk("start_mac_go", bus.mac_go, 1);
    @(posedge clk); #1;
    stream(who, av, bv, 16, gap_at, gap_len, spur_at, drop);
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ready_drop", {bus.opd_ready1, bus.opd_ready0}, 0);
      hit = (who == 0) ? bus.rsp_valid0 : bus.rsp_valid1;
      if (!hit) begin @(posedge clk); #1; end
    end
    chk("rsp_latency", n, exp_wait);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("mac_en_count", en_cnt, 16);
    chk("other_rsp_valid", (who == 0) ? bus.rsp_valid1 : bus.rsp_valid0, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors = 0; miscompares = 0; v0cnt = 0; v1cnt = 0;
    rst = 1'b1; done_en = 1'b1; spur_done = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.opd_valid0 = 1'b0; bus.opd_valid1 = 1'b0;
    bus.a0 = 4'd5; bus.b0 = 4'd6; bus.a1 = 4'd0; bus.b1 = 4'd0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("rst_ctl", {bus.mac_go, bus.mac_en, bus.opd_ready1, bus.opd_ready0}, 0);
    chk("rst_rsp", {bus.rsp_valid1, bus.rsp_valid0, bus.rsp_err}, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_mac_ab", {bus.mac_a, bus.mac_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single requester, 16 x (3*2)
    bus.req0 = 1'b1;
    job(0, 4'd3, 4'd2, -1, 0, -1, 1'b0, 12'd96, 1'b0, 3);
    bus.req0 = 1'b0;

    // tie after reset: 0, then 1, then 0 again
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    job(0, 4'd2, 4'd2, -1, 0, -1, 1'b0, 12'd64, 1'b0, 3);
    job(1, 4'd4, 4'd3, -1, 0, -1, 1'b0, 12'd192, 1'b0, 3);
    job(0, 4'd1, 4'd9, -1, 0, -1, 1'b0, 12'd144, 1'b0, 3);
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // 5-cycle valid stall after pair 7 with request dropped: 16 x 35
    bus.req1 = 1'b1;
    job(1, 4'd5, 4'd7, 7, 5, -1, 1'b1, 12'd560, 1'b0, 3);
    chk("req_dropped", bus.req1, 0);

    // response holds; mac_done while idle is ignored
    spur_done = 1'b1;
    @(negedge clk);
    chk("hold_data", bus.rsp_data, 560);
    chk("hold_err", bus.rsp_err, 0);
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(negedge clk);
    chk("idle_spur", {bus.gnt1, bus.gnt0, bus.rsp_valid1, bus.rsp_valid0}, 0);
    @(posedge clk); #1;

    // MAC never completes: timeout after 15 WAIT cycles
    done_en = 1'b0;
    bus.req0 = 1'b1;
    job(0, 4'd1, 4'd1, -1, 0, -1, 1'b0, 12'd0, 1'b1, 16);
    bus.req0 = 1'b0;
    done_en = 1'b1;

    // maximum sum with a spurious mac_done during STREAM
    bus.req1 = 1'b1;
    job(1, 4'd15, 4'd15, -1, 0, 4, 1'b0, 12'd3600, 1'b0, 3);
    bus.req1 = 1'b0;

    // reset after 7 pairs, then a clean job
    bus.req0 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stream(0, 4'd2, 4'd3, 7, -1, 0, -1, 1'b0);
    bus.opd_valid0 = 1'b1;
    #1;
    chk("pre_rst_ready", bus.opd_ready0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("mid_rst_ctl", {bus.mac_go, bus.mac_en, bus.opd_ready1, bus.opd_ready0}, 0);
    chk("mid_rst_rsp", {bus.rsp_valid1, bus.rsp_valid0, bus.rsp_err}, 0);
    chk("mid_rst_data", bus.rsp_data, 0);
    chk("mid_rst_mac_a", bus.mac_a, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_no_rsp", {bus.rsp_valid1, bus.rsp_valid0}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.opd_valid0 = 1'b0;
    job(0, 4'd2, 4'd3, -1, 0, -1, 1'b0, 12'd96, 1'b0, 3);
    bus.req0 = 1'b0;

    // total response pulses per requester
    @(negedge clk);
    chk("rsp0_pulses", v0cnt, 5);
    chk("rsp1_pulses", v1cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
